// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder for the MEM stage: performs one word access after
// LATENCY cycles and stalls the pipeline until the access completes.
module dmem_responder #(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 3
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_read,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        mem_stall,
  output logic [31:0] rdata,
  output logic        rvalid,
  output logic        err
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  localparam logic [3:0] LAT = 4'(LATENCY);

  state_e              state_q;
  logic [3:0]          cnt_q;
  logic                write_q;
  logic                errPend_q;
  logic [ADDR_W-1:0]   idx_q;
  logic [31:0]         wdata_q;
  logic [31:0]         rdata_q;
  logic                rvalid_q;
  logic                err_q;
  logic [31:0]         mem_q [2**ADDR_W];

  logic                reqAny;
  logic                commit;
  logic [ADDR_W-1:0]   reqIdx;
  logic                unused_addrHigh;

  assign reqAny = req_read | req_write;
  assign commit = (state_q == BUSY) && (cnt_q == 4'd1);
  assign reqIdx = req_addr[ADDR_W+1:2];

  // Upper address bits are deliberately dropped so accesses wrap modulo the memory size.
  assign unused_addrHigh = ^req_addr[31:ADDR_W+2];

  assign mem_stall = !reset && (((state_q == IDLE) && reqAny) || (state_q == BUSY));
  assign rdata     = rdata_q;
  assign rvalid    = rvalid_q;
  assign err       = err_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      write_q   <= 1'b0;
      errPend_q <= 1'b0;
      idx_q     <= '0;
      wdata_q   <= 32'd0;
      rdata_q   <= 32'd0;
      rvalid_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      case (state_q)
        IDLE: begin
          if (reqAny) begin
            // A read+write conflict executes as a write and is flagged.
            write_q   <= req_write;
            errPend_q <= (req_addr[1:0] != 2'b00) || (req_read && req_write);
            idx_q     <= reqIdx;
            wdata_q   <= req_wdata;
            cnt_q     <= LAT;
            state_q   <= BUSY;
          end
        end
        BUSY: begin
          cnt_q <= cnt_q - 4'd1;
          if (commit) begin
            if (!write_q) begin
              rdata_q <= mem_q[idx_q];
            end
            rvalid_q <= 1'b1;
            err_q    <= errPend_q;
            state_q  <= DONE;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // The array has no reset; a write only lands on a commit edge where reset is low.
  always_ff @(posedge clock) begin
    if (!reset && commit && write_q) begin
      mem_q[idx_q] <= wdata_q;
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: one instance at LATENCY=3, one at LATENCY=1,
// selected through a shared request bus.
module tb_dmem_responder;

  logic        clock = 1'b0;
  logic        reset;
  logic        drvSel;
  logic        drvRead;
  logic        drvWrite;
  logic [31:0] drvAddr;
  logic [31:0] drvWdata;

  logic        stall3, rvalid3, err3;
  logic [31:0] rdata3;
  logic        stall1, rvalid1, err1;
  logic [31:0] rdata1;

  logic        obsStall, obsRvalid, obsErr;
  logic [31:0] obsRdata;

  int assertCount = 0;
  int failCount   = 0;

  always #5 clock = ~clock;

  dmem_responder #(.ADDR_W(10), .LATENCY(3)) dut3 (
    .clock     (clock),
    .reset     (reset),
    .req_read  (drvRead  & ~drvSel),
    .req_write (drvWrite & ~drvSel),
    .req_addr  (drvAddr),
    .req_wdata (drvWdata),
    .mem_stall (stall3),
    .rdata     (rdata3),
    .rvalid    (rvalid3),
    .err       (err3)
  );

  dmem_responder #(.ADDR_W(10), .LATENCY(1)) dut1 (
    .clock     (clock),
    .reset     (reset),
    .req_read  (drvRead  & drvSel),
    .req_write (drvWrite & drvSel),
    .req_addr  (drvAddr),
    .req_wdata (drvWdata),
    .mem_stall (stall1),
    .rdata     (rdata1),
    .rvalid    (rvalid1),
    .err       (err1)
  );

  assign obsStall  = drvSel ? stall1  : stall3;
  assign obsRvalid = drvSel ? rvalid1 : rvalid3;
  assign obsErr    = drvSel ? err1    : err3;
  assign obsRdata  = drvSel ? rdata1  : rdata3;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertCount++;
    assert (observed === expected)
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Issue one request at the current negedge and hold it through DONE; returns at the
  // negedge of the cycle after DONE so the next call is back-to-back.
  task automatic applyStimulus(input bit s, input bit rd, input bit wr, input logic [31:0] addr,
                               input logic [31:0] wd, input logic [31:0] expRd, input bit expErr,
                               input string tag);
    int lat;
    int stalls;
    int pulses;
    lat    = s ? 1 : 3;
    stalls = 0;
    pulses = 0;
    drvSel   = s;
    drvRead  = rd;
    drvWrite = wr;
    drvAddr  = addr;
    drvWdata = wd;
    for (int c = 0; c <= lat + 1; c++) begin
      #1;
      if (obsStall)  stalls++;
      if (obsRvalid) pulses++;
      if (c == lat) begin
        checkOutput({tag, ".stallLast"}, {31'd0, obsStall}, 32'd1);
      end
      if (c == lat + 1) begin
        checkOutput({tag, ".rvalid"}, {31'd0, obsRvalid}, 32'd1);
        checkOutput({tag, ".stallDone"}, {31'd0, obsStall}, 32'd0);
        checkOutput({tag, ".err"}, {31'd0, obsErr}, {31'd0, expErr});
        checkOutput({tag, ".rdata"}, obsRdata, expRd);
      end
      @(negedge clock);
    end
    checkOutput({tag, ".stallCycles"}, stalls, lat + 1);
    checkOutput({tag, ".rvalidPulses"}, pulses, 1);
    drvRead  = 1'b0;
    drvWrite = 1'b0;
  endtask

  logic [31:0] model [1024];
  logic [31:0] lastRd1;
  bit          swRd   [8] = '{0, 0, 1, 1, 0, 1, 0, 1};
  logic [31:0] swAddr [8] = '{32'h40, 32'h44, 32'h40, 32'h44, 32'h40, 32'h40, 32'h1048, 32'h48};
  logic [31:0] swData [8] = '{32'h0000_1111, 32'h2222_0000, 32'h0, 32'h0,
                              32'h3333_4444, 32'h0, 32'h5555_6666, 32'h0};

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset    = 1'b1;
    drvSel   = 1'b0;
    drvRead  = 1'b1;
    drvWrite = 1'b0;
    drvAddr  = 32'h0;
    drvWdata = 32'h0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    checkOutput("reset.stall3", {31'd0, stall3}, 32'd0);
    checkOutput("reset.rvalid3", {31'd0, rvalid3}, 32'd0);
    checkOutput("reset.err3", {31'd0, err3}, 32'd0);
    checkOutput("reset.rdata3", rdata3, 32'd0);
    checkOutput("reset.rdata1", rdata1, 32'd0);
    reset   = 1'b0;
    drvRead = 1'b0;
    @(negedge clock);

    applyStimulus(0, 0, 1, 32'h10,   32'hDEAD_BEEF, 32'h0,         0, "wr10");
    applyStimulus(0, 1, 0, 32'h10,   32'h0,         32'hDEAD_BEEF, 0, "rd10");
    applyStimulus(0, 0, 1, 32'h20,   32'h1234_5678, 32'hDEAD_BEEF, 0, "wr20");
    applyStimulus(0, 1, 0, 32'h20,   32'h0,         32'h1234_5678, 0, "rd20");
    applyStimulus(0, 1, 0, 32'h13,   32'h0,         32'hDEAD_BEEF, 1, "rdMis13");
    applyStimulus(0, 1, 1, 32'h8,    32'hA5A5_A5A5, 32'hDEAD_BEEF, 1, "conflict8");
    applyStimulus(0, 1, 0, 32'h8,    32'h0,         32'hA5A5_A5A5, 0, "rd8");
    applyStimulus(0, 0, 1, 32'h1004, 32'h1,         32'hA5A5_A5A5, 0, "wrWrap");
    applyStimulus(0, 1, 0, 32'h4,    32'h0,         32'h1,         0, "rdWrap");
    applyStimulus(0, 0, 1, 32'h30,   32'h1111_2222, 32'h1,         0, "wr30");

    drvSel   = 1'b0;
    drvWrite = 1'b1;
    drvAddr  = 32'h30;
    drvWdata = 32'h0BAD_F00D;
    @(negedge clock);
    reset    = 1'b1;
    drvWrite = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    #1;
    checkOutput("abort.stall", {31'd0, stall3}, 32'd0);
    checkOutput("abort.rvalid", {31'd0, rvalid3}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      checkOutput($sformatf("abort.idleRvalid%0d", i), {31'd0, rvalid3}, 32'd0);
      checkOutput($sformatf("abort.idleStall%0d", i), {31'd0, stall3}, 32'd0);
    end
    applyStimulus(0, 1, 0, 32'h30, 32'h0, 32'h1111_2222, 0, "rd30AfterAbort");

    lastRd1 = 32'h0;
    for (int i = 0; i < 8; i++) begin
      if (swRd[i]) lastRd1 = model[swAddr[i][11:2]];
      else         model[swAddr[i][11:2]] = swData[i];
      applyStimulus(1, swRd[i], !swRd[i], swAddr[i], swData[i], lastRd1, 0,
                    $sformatf("sweep%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
